// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// Hits are answered combinationally in IDLE; a miss latches the address and
// stays in FETCH until the memory controller drops iwait. The fill then
// completes, even if the datapath request changes or goes away meanwhile.
module icache #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = 30 - IdxW;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic              valid_q [SETS];
    logic [TagW-1:0]   tag_q   [SETS];
    logic [31:0]       data_q  [SETS];

    logic [IdxW-1:0]   req_idx, fill_idx;
    logic [TagW-1:0]   req_tag, fill_tag;
    logic              hit;
    logic              fill_en;

    assign req_idx  = imemaddr[IdxW+1:2];
    assign req_tag  = imemaddr[31:IdxW+2];
    assign fill_idx = miss_addr_q[IdxW+1:2];
    assign fill_tag = miss_addr_q[31:IdxW+2];
    assign fill_en  = (state_q == StFetch) && !iwait;

    // Lookup, datapath/memory outputs and next-state; outputs forced quiet while in reset.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        hit         = 1'b0;
        ihit        = 1'b0;
        imemload    = 32'h0;
        iREN        = 1'b0;
        iaddr       = 32'h0;

        if (nRST && (state_q == StIdle) && imemREN && valid_q[req_idx]) begin
            hit = (tag_q[req_idx] == req_tag);
        end

        ihit = hit;
        if (hit) begin
            imemload = data_q[req_idx];
        end

        if (nRST && (state_q == StFetch)) begin
            iREN  = 1'b1;
            iaddr = miss_addr_q;
        end

        unique case (state_q)
            StIdle: begin
                if (imemREN && !hit) begin
                    miss_addr_d = imemaddr;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (!iwait) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and miss-address registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= StIdle;
            miss_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Valid bits: cleared by reset, which also wins over a fill in the same cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data arrays are never reset; they are only visible through a set valid bit.
    always_ff @(posedge CLK) begin
        if (nRST && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a per-cycle vector table followed by
// hand-written sequences for mid-fill address change, reset during fill and
// a full sweep of all frames.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    int checks = 0;
    int errors = 0;

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .imemload (imemload),
        .ihit     (ihit),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst;
        logic        ren;
        logic [31:0] addr;
        logic        iwait;
        logic [31:0] iload;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vecs[25];

    // Drive one cycle's inputs just after the falling edge; outputs are then
    // sampled a little later, well before the next rising edge.
    task automatic step(input logic nrst, input logic ren, input logic [31:0] addr,
                        input logic wt, input logic [31:0] ld);
        @(negedge CLK);
        nRST     = nrst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        #1;
    endtask

    task automatic chk(input string name, input logic e_hit, input logic [31:0] e_load,
                       input logic e_iren, input logic [31:0] e_iaddr);
        checks++;
        if (ihit !== e_hit || imemload !== e_load || iREN !== e_iren || iaddr !== e_iaddr) begin
            errors++;
            $display("FAIL %s: got ihit=%b imemload=%h iREN=%b iaddr=%h, want ihit=%b imemload=%h iREN=%b iaddr=%h",
                     name, ihit, imemload, iREN, iaddr, e_hit, e_load, e_iren, e_iaddr);
        end
    endtask

    initial begin
        // nrst ren addr iwait iload | ihit imemload iREN iaddr
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        // cold miss on 0x40, three wait cycles, then data
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h8C22_0004, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h8C22_0004, 1'b0, 32'h0};
        // halt: valid matching frame but no request
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h8C22_0004, 1'b0, 32'h0};
        // conflict on index 0: 0x80 evicts 0x40
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h1111_2222, 1'b0, 32'h0,         1'b1, 32'h80};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0,         1'b1, 32'h1111_2222, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        // request dropped mid-fill: fill still completes
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h8C22_0004, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[15] = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h8C22_0004, 1'b0, 32'h0};
        // top of address space: index 15, all-ones tag
        vecs[16] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[17] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC};
        vecs[18] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 1'b1, 32'h0000_003C, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[20] = '{1'b1, 1'b1, 32'h0000_003C, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, 32'h3C};
        vecs[21] = '{1'b1, 1'b1, 32'h0000_003C, 1'b1, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[22] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[23] = '{1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC};
        // index 0 untouched by index-15 traffic
        vecs[24] = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h8C22_0004, 1'b0, 32'h0};

        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].nrst, vecs[i].ren, vecs[i].addr, vecs[i].iwait, vecs[i].iload);
            chk($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load, vecs[i].e_iren,
                vecs[i].e_iaddr);
        end

        // Address change mid-fill: iaddr holds 0x100, frame 0 takes 0x100's tag.
        step(1'b0, 1'b0, 32'h0,     1'b1, 32'h0);         chk("mid_rst",   0, 32'h0, 0, 32'h0);
        step(1'b1, 1'b1, 32'h100,   1'b1, 32'h0);         chk("mid_miss",  0, 32'h0, 0, 32'h0);
        step(1'b1, 1'b1, 32'h200,   1'b1, 32'h0);         chk("mid_hold",  0, 32'h0, 1, 32'h100);
        step(1'b1, 1'b0, 32'h200,   1'b0, 32'hAAAA_0100); chk("mid_done",  0, 32'h0, 1, 32'h100);
        step(1'b1, 1'b1, 32'h100,   1'b1, 32'h0);         chk("mid_hit",   1, 32'hAAAA_0100, 0, 32'h0);
        step(1'b1, 1'b1, 32'h200,   1'b1, 32'h0);         chk("mid_miss2", 0, 32'h0, 0, 32'h0);
        step(1'b1, 1'b1, 32'h200,   1'b0, 32'hBBBB_0200); chk("mid_fill2", 0, 32'h0, 1, 32'h200);
        step(1'b1, 1'b1, 32'h200,   1'b1, 32'h0);         chk("mid_hit2",  1, 32'hBBBB_0200, 0, 32'h0);

        // Reset in FETCH together with iwait=0: fill abandoned.
        step(1'b1, 1'b1, 32'h140,   1'b1, 32'h0);         chk("rf_miss",   0, 32'h0, 0, 32'h0);
        step(1'b0, 1'b1, 32'h140,   1'b0, 32'hCCCC_0140); chk("rf_rst",    0, 32'h0, 0, 32'h0);
        step(1'b1, 1'b0, 32'h140,   1'b1, 32'h0);         chk("rf_idle",   0, 32'h0, 0, 32'h0);
        step(1'b1, 1'b1, 32'h140,   1'b1, 32'h0);         chk("rf_remiss", 0, 32'h0, 0, 32'h0);
        step(1'b1, 1'b1, 32'h140,   1'b0, 32'hDDDD_0140); chk("rf_fetch",  0, 32'h0, 1, 32'h140);
        step(1'b1, 1'b1, 32'h140,   1'b1, 32'h0);         chk("rf_hit",    1, 32'hDDDD_0140, 0, 32'h0);

        // Full sweep of all 16 frames, then zero-wait re-reads.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("sw_rst", 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'(i) * 32'd4;
            d = 32'h1000_0000 | (32'(i) * 32'h0101);
            step(1'b1, 1'b1, a, 1'b1, 32'h0);
            chk($sformatf("sw_miss%0d", i), 0, 32'h0, 0, 32'h0);
            step(1'b1, 1'b1, a, 1'b0, d);
            chk($sformatf("sw_fill%0d", i), 0, 32'h0, 1, a);
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'(i) * 32'd4;
            d = 32'h1000_0000 | (32'(i) * 32'h0101);
            step(1'b1, 1'b1, a, 1'b1, 32'h0);
            chk($sformatf("sw_hit%0d", i), 1, d, 0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
